counter_countdown: RTL and testbench
====================================

Name: counter_countdown

Overview:
- Loadable down-counter (timer): the count-down counterpart of the team's up-counter, using the same d/q/load/enable interface.
- Counts a loaded value down to zero and emits a one-cycle terminal-count pulse, `tc`.
- Supports one-shot and periodic (auto-reload) operation.
- Used for pipeline stall timers, multi-cycle unit timeouts and periodic tick generation.

Parameters:
- MAX, 12: largest loadable count; `d` above MAX saturates to MAX.
- WIDTH, $clog2(MAX+1) (4 at the default): width of `d`, `q` and the reload register.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- d  in  WIDTH  load value.
- load  in  1  capture `d` into the count and reload registers.
- enable  in  1  decrement permission; count holds when low.
- periodic  in  1  1 = auto-reload on expiry; 0 = one-shot. Sampled each cycle.
- q  out  WIDTH  current count.
- tc  out  1  terminal-count pulse, one cycle wide, registered.
- busy  out  1  high while the state is RUN.

Behaviour:
- Reset (reset_n=0, takes effect immediately with no clock edge):
  - q=0, reload=0, tc=0, busy=0, state=IDLE.
  - Reset mid-run aborts the run; no tc is emitted.
- States: IDLE, RUN, EXPIRE.
- Load value: ld = (d > MAX) ? MAX : d.
- Load priority: load=1 overrides every other input in every state.
  - q<=ld and reload<=ld.
  - If ld!=0, go to RUN; if ld==0, go to IDLE.
  - tc<=0 that cycle, including when the load coincides with an expiry.
- IDLE:
  - q holds; enable is ignored; tc=0.
- RUN, enable=0:
  - q holds; tc=0.
- RUN, enable=1, q>1:
  - q<=q-1; tc=0.
- RUN, enable=1, q==1, periodic=0:
  - q<=0, tc<=1, go to EXPIRE.
- RUN, enable=1, q==1, periodic=1:
  - q<=reload, tc<=1, stay in RUN.
  - q never shows 0; the period is `reload` enabled cycles.
- EXPIRE:
  - Lasts one cycle with q=0 and tc=1, then goes to IDLE with tc<=0.
  - A load during EXPIRE is accepted: next state RUN or IDLE per ld, and tc<=0.
- tc timing:
  - tc is high for exactly one cycle.
  - tc is aligned with the cycle in which q first shows 0 (one-shot) or the reloaded value (periodic).
- busy:
  - busy = (state==RUN), registered alongside the state.
- Latency:
  - Load to q valid: 1 edge.
  - N enabled edges after a load of N: tc asserted.
- Width/arithmetic:
  - q never underflows; the decrement is only applied when q>=2 in RUN.
  - d comparison with MAX is unsigned.

Optional Feature:
- Macro: COUNTER_COUNTDOWN_STICKY_EN
- Defined:
  - Adds output port `expired` (1 bit).
  - Set on any cycle where tc<=1.
  - Cleared by reset_n=0 or by an accepted load.
  - Set wins over clear only when both occur in the same cycle, which cannot happen because a load suppresses tc.
  - Lets slow consumers observe expiry after the tc pulse has passed.
- Not defined: the `expired` port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset and idle:
  - Stimulus: reset_n=0 for 2 cycles mid-stream, then release; enable=1 with no load for 4 cycles.
  - Response: q=0, tc=0, busy=0 immediately on reset, and q remains 0 after release.
- One-shot count:
  - Stimulus: load d=5 with periodic=0, then enable=1.
  - Response: q=5,4,3,2,1,0 on successive edges; tc=1 only in the q=0 cycle; busy drops in that same cycle; next cycle state is IDLE and tc=0.
- Saturation and zero load:
  - Stimulus: load d=15, then load d=0.
  - Response: d=15 gives q=12 and busy=1; d=0 gives q=0, busy=0 and no tc.
- Periodic reload:
  - Stimulus: periodic=1, load d=3, enable=1 continuously for 10 edges.
  - Response: q=3,2,1,3,2,1,3,...; tc high in each cycle where q returns to 3 after reload, i.e. every 3 cycles.
- Hold and load override:
  - Stimulus: load 6, run to q=4, drop enable for 3 cycles, then reassert; separately, load 7 in the same cycle that q==1 with enable=1.
  - Response: q holds at 4 for 3 cycles, then resumes 3,2,...; the coincident load gives q=7 with tc=0.
- Asynchronous reset mid-run and sticky flag (with COUNTER_COUNTDOWN_STICKY_EN):
  - Stimulus: pull reset_n low between edges while q=9.
  - Response: q=0, busy=0, expired=0 before the next edge.
  - Stimulus: run a one-shot load of 2 to expiry.
  - Response: expired=1 stays high until the next load.

Source files
------------

// File: rtl/counter_countdown.sv
// ---------------------------------------------------------------------------
// counter_countdown
//
// Loadable down-counter (timer). A load captures d (saturated to MAX) into
// both the live count and the reload register. While running, each enabled
// cycle decrements the count. When the count expires, a one-cycle,
// registered terminal-count pulse (tc) is produced.
//
//   one-shot : q goes 1 -> 0. tc is high in the cycle that shows q=0. The
//              state passes through EXPIRE for that cycle, then to IDLE.
//   periodic : q goes 1 -> reload. tc is high in the cycle that shows the
//              reloaded value. The state stays in RUN, so q never reads 0.
//
// A load has priority over every other input in every state, and it
// suppresses tc in the cycle it is accepted.
//
// Optional build macro: COUNTER_COUNTDOWN_STICKY_EN
//   When it is defined, the macro adds an `expired` output. The flag is set
//   whenever tc is issued and stays set until reset or the next accepted
//   load, so a slow consumer can still see an expiry after the tc pulse.
// ---------------------------------------------------------------------------
module counter_countdown #(
  parameter int MAX   = 12,
  parameter int WIDTH = $clog2(MAX + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  input  logic             enable,
  input  logic             periodic,
  output logic [WIDTH-1:0] q,
  output logic             tc,
`ifdef COUNTER_COUNTDOWN_STICKY_EN
  output logic             expired,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W = '0;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;
  logic             busy_nxt;
  logic [WIDTH-1:0] ld;

  // Saturate the load value to MAX; the comparison is unsigned.
  always_comb begin
    ld = (d > MAX_W) ? MAX_W : d;
  end

  // Next-state, next-count and terminal-count decode.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    reload_nxt = reload;
    tc_nxt     = 1'b0;

    if (load) begin
      // A load wins over everything, including a coincident expiry.
      q_nxt      = ld;
      reload_nxt = ld;
      state_nxt  = (ld != ZERO_W) ? RUN : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          // The count holds and enable is ignored.
        end

        RUN: begin
          if (enable) begin
            if (q > ONE_W) begin
              q_nxt = q - ONE_W;
            end else if (q == ONE_W) begin
              tc_nxt = 1'b1;
              if (periodic) begin
                q_nxt = reload;
              end else begin
                q_nxt     = ZERO_W;
                state_nxt = EXPIRE;
              end
            end else begin
              // q==0 cannot occur in RUN; leave quietly rather than underflow.
              state_nxt = IDLE;
            end
          end
        end

        EXPIRE: begin
          // The single cycle showing q=0 and tc=1 is over; go back to idle.
          state_nxt = IDLE;
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    busy_nxt = (state_nxt == RUN);
  end

  // State, count, reload and registered outputs.
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before the edge, whatever order the statements run in.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      q      <= '0;
      reload <= '0;
      tc     <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      reload <= reload_nxt;
      tc     <= tc_nxt;
      busy   <= busy_nxt;
    end
  end

`ifdef COUNTER_COUNTDOWN_STICKY_EN
  // Sticky expiry flag: set whenever tc is issued, cleared by a load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      expired <= 1'b0;
    end else if (tc_nxt) begin
      expired <= 1'b1;
    end else if (load) begin
      expired <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_counter_countdown.sv
// ---------------------------------------------------------------------------
// tb_counter_countdown
//
// Table-driven bench for counter_countdown, followed by hand-written
// sequences for reset, the sticky flag, and the periodic tick rate.
// Optional build macro: COUNTER_COUNTDOWN_STICKY_EN (also checks `expired`).
// ---------------------------------------------------------------------------
module tb_counter_countdown;

  logic       clock;
  logic       reset_n;
  logic [3:0] d;
  logic       load;
  logic       enable;
  logic       periodic;
  logic [3:0] q;
  logic       tc;
  logic       busy;
`ifdef COUNTER_COUNTDOWN_STICKY_EN
  logic       expired;
`endif

  int total = 0;
  int bad   = 0;
  logic exp_sticky;

  counter_countdown dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .d        (d),
    .load     (load),
    .enable   (enable),
    .periodic (periodic),
    .q        (q),
    .tc       (tc),
`ifdef COUNTER_COUNTDOWN_STICKY_EN
    .expired  (expired),
`endif
    .busy     (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       load;
    logic [3:0] d;
    logic       enable;
    logic       periodic;
    logic [3:0] q;
    logic       tc;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic l, logic [3:0] dd, logic en, logic p,
                             logic [3:0] eq, logic etc, logic eb);
    vec_t r;
    r.load = l; r.d = dd; r.enable = en; r.periodic = p;
    r.q = eq; r.tc = etc; r.busy = eb;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(logic l, logic [3:0] dd, logic en, logic p);
    load = l; d = dd; enable = en; periodic = p;
  endtask

  task automatic check_outs(string tag, logic [3:0] eq, logic etc, logic eb);
    check({tag, ".q"}, 32'(q), 32'(eq));
    check({tag, ".tc"}, 32'(tc), 32'(etc));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
  endtask

  task automatic check_sticky(string tag, logic e);
`ifdef COUNTER_COUNTDOWN_STICKY_EN
    check({tag, ".expired"}, 32'(expired), 32'(e));
`else
    if (e === 1'bx) $display("unused %s", tag);
`endif
  endtask

  initial begin
    int n;
    int tcs;

    // idle: enable is ignored
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0));
    // one-shot 5
    vecs.push_back(v(1, 5, 1, 0, 5, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 4, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 3, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 2, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0));
    // saturation and zero load
    vecs.push_back(v(1, 15, 0, 0, 12, 0, 1));
    vecs.push_back(v(1, 13, 0, 0, 12, 0, 1));
    vecs.push_back(v(1, 12, 1, 0, 12, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 11, 0, 1));
    vecs.push_back(v(1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 0));
    // periodic 3
    vecs.push_back(v(1, 3, 1, 1, 3, 0, 1));
    vecs.push_back(v(0, 0, 1, 1, 2, 0, 1));
    vecs.push_back(v(0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(v(0, 0, 1, 1, 3, 1, 1));
    vecs.push_back(v(0, 0, 1, 1, 2, 0, 1));
    vecs.push_back(v(0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(v(0, 0, 1, 1, 3, 1, 1));
    vecs.push_back(v(0, 0, 1, 1, 2, 0, 1));
    vecs.push_back(v(0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(v(0, 0, 1, 1, 3, 1, 1));
    vecs.push_back(v(0, 0, 1, 1, 2, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0));
    // periodic reload of 1: tc every enabled cycle
    vecs.push_back(v(1, 1, 1, 1, 1, 0, 1));
    vecs.push_back(v(0, 0, 1, 1, 1, 1, 1));
    vecs.push_back(v(0, 0, 1, 1, 1, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0));
    // hold with enable low, then load coincident with q==1
    vecs.push_back(v(1, 6, 1, 0, 6, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 5, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 4, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 4, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 4, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 4, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 3, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 2, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(v(1, 7, 1, 0, 7, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 6, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0));
    // load accepted during EXPIRE
    vecs.push_back(v(1, 2, 1, 0, 2, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(v(1, 4, 1, 0, 4, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 4, 0, 1));
    // periodic sampled every cycle: dropped just before expiry
    vecs.push_back(v(1, 2, 1, 1, 2, 0, 1));
    vecs.push_back(v(0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 0, 0));
    // load coincident with a periodic expiry
    vecs.push_back(v(1, 2, 1, 1, 2, 0, 1));
    vecs.push_back(v(0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(v(1, 5, 1, 1, 5, 0, 1));
    vecs.push_back(v(0, 0, 1, 1, 4, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0));

    // reset from a clean negedge, before any clock edge
    reset_n = 1'b1;
    drive(0, 0, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    check_outs("reset", 0, 0, 0);
    check_sticky("reset", 0);
    step();
    step();
    reset_n = 1'b1;
    exp_sticky = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].load, vecs[i].d, vecs[i].enable, vecs[i].periodic);
      step();
      if (vecs[i].tc) exp_sticky = 1'b1;
      else if (vecs[i].load) exp_sticky = 1'b0;
      check_outs($sformatf("vec%0d", i), vecs[i].q, vecs[i].tc, vecs[i].busy);
      check_sticky($sformatf("vec%0d", i), exp_sticky);
    end

    // sticky flag: one-shot 2 run to expiry, held until the next load
    drive(1, 2, 1, 0); step(); check_outs("st0", 2, 0, 1); check_sticky("st0", 0);
    drive(0, 0, 1, 0); step(); check_outs("st1", 1, 0, 1);
    step(); check_outs("st2", 0, 1, 0); check_sticky("st2", 1);
    step(); check_outs("st3", 0, 0, 0); check_sticky("st3", 1);
    step(); step(); check_sticky("st4", 1);
    drive(1, 9, 1, 0); step(); check_outs("st5", 9, 0, 1); check_sticky("st5", 0);

    // asynchronous reset between edges while q=9
    drive(0, 0, 1, 0);
    #2 reset_n = 1'b0;
    #1;
    check_outs("arst", 0, 0, 0);
    check_sticky("arst", 0);
    step(); check_outs("arst_hold0", 0, 0, 0);
    step(); check_outs("arst_hold1", 0, 0, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_outs($sformatf("post_rst%0d", k), 0, 0, 0);
    end

    // reset clears a set sticky flag without a clock edge
    drive(1, 1, 1, 0); step(); check_outs("sr0", 1, 0, 1);
    drive(0, 0, 1, 0); step(); check_outs("sr1", 0, 1, 0); check_sticky("sr1", 1);
    #2 reset_n = 1'b0;
    #1 check_sticky("sr_rst", 0);
    check_outs("sr_rst", 0, 0, 0);
    step();
    reset_n = 1'b1;

    // bounded wait: one-shot 12 expires after exactly 12 enabled edges
    drive(1, 12, 1, 0); step();
    drive(0, 0, 1, 0);
    n = 0;
    do begin
      step();
      n++;
    end while (!tc && n < 20);
    check("oneshot12_latency", 32'(n), 32'd12);
    check("oneshot12_q", 32'(q), 32'd0);

    // periodic 4: 20 enabled edges give 5 ticks
    drive(1, 4, 1, 1); step();
    drive(0, 0, 1, 1);
    tcs = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (tc) tcs++;
    end
    check("periodic4_ticks", 32'(tcs), 32'd5);
    check("periodic4_q", 32'(q), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
